pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register. With SKID=1 it holds up
//               to two entries (main + skid) so that in_ready is a register
//               with no combinational path from out_ready. With SKID=0 it is
//               a single register whose in_ready is combinational. Also counts
//               bubble cycles (out_valid low) with saturation.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-low reset
//               in_valid   - upstream payload valid
//               in_ready   - stage can accept the payload
//               in_data    - upstream payload [WIDTH]
//               out_valid  - out_data valid
//               out_ready  - downstream accepts
//               out_data   - registered payload [WIDTH]
//               flush      - synchronous discard of all held entries
//               cnt_clr    - synchronous clear of bubble_cnt
//               occupancy  - entries held (0..2)
//               bubble_cnt - saturating count of cycles with out_valid low
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  parameter bit               SKID      = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_accept;
  logic w_deliver;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign bubble_cnt = r_bubble_cnt;

  // --------------------------------------------------------------------------
  // Next-state and datapath load controls. With SKID=0 the ready equation
  // makes accept-without-deliver in ST_ONE impossible, so ST_FULL is never
  // entered and the same decode serves both variants.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_next_state = ST_FULL;
            w_load_skid  = 1'b1;
          end else if (w_deliver) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_deliver) begin
            w_next_state     = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Main holds its last value when emptied by a delivery; only flush and
  // reset return it to CLEAR_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= CLEAR_VAL;
      r_skid <= CLEAR_VAL;
    end else if (flush) begin
      r_main <= CLEAR_VAL;
      r_skid <= CLEAR_VAL;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : in_data;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Ready generation.
  // --------------------------------------------------------------------------
  generate
    if (SKID) begin : g_skid
      // Registered ready: low exactly when the skid entry is occupied.
      logic r_in_ready;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_next_state != ST_FULL);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_no_skid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bubble counter: counts edges where out_valid was low, saturating.
  // cnt_clr has priority; flush does not affect it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if (!out_valid && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire
